bank_wbuf_responder: RTL and testbench
======================================

// Module: bank_wbuf_responder
// PURPOSE
//   Bank-side write buffer: responder end of the rc_wbuf req/rtn interface used by the bank SRAM
//   controller. Holds write data pushed by the xbar per {channel, wbuffer_id} slot; on a read
//   request it returns that slot's 128-bit data one cycle later and frees the slot.
// PARAMETERS
//   CH_NUM     4    number of channels (channel_id width = 2)
//   ENTRY_NUM  4    slots per channel, power of 2; slot index = wbuffer_id[log2(ENTRY_NUM)-1:0]
//   DW         128  data width
//   DEPTH      CH_NUM*ENTRY_NUM (derived); CW = $clog2(DEPTH+1) (derived)
// PORTS
//   clk_i                     in   1    clock
//   rst_i                     in   1    reset, asynchronous, active-high
//   xbar_wbuf_valid_i         in   1    fill request valid
//   xbar_wbuf_ready_o         out  1    fill accepted (target slot free)
//   xbar_wbuf_channel_id_i    in   2    fill channel
//   xbar_wbuf_wbuffer_id_i    in   8    fill slot id (upper bits ignored)
//   xbar_wbuf_data_i          in   DW   fill data
//   rc_wbuf_req_valid_i       in   1    read request valid from SRAM controller
//   rc_wbuf_req_ready_o       out  1    read request accepted
//   rc_wbuf_req_channel_id_i  in   2    read channel
//   rc_wbuf_req_wbuffer_id_i  in   8    read slot id (upper bits ignored)
//   rc_wbuf_rtn_valid_o       out  1    return data valid
//   rc_wbuf_rtn_ready_i       in   1    return data consumed
//   rc_wbuf_rtn_data_o        out  DW   return data
//   wbuf_valid_cnt_o          out  CW   number of occupied slots
// BEHAVIOUR
//   - Slot address a = {channel_id, wbuffer_id[log2(ENTRY_NUM)-1:0]}; per slot: valid bit + DW data.
//   - Reset: all slot valid=0, rc_wbuf_rtn_valid_o=0, rc_wbuf_rtn_data_o=0, wbuf_valid_cnt_o=0,
//     hence xbar_wbuf_ready_o=1 and rc_wbuf_req_ready_o=0. Slot data array is not reset.
//     Reset mid-operation discards all slots and any pending return; no handshake completes.
//   - Fill: xbar_wbuf_ready_o = ~valid_Q[a_fill] (combinational, registered state only).
//     Fill fire -> next cycle valid[a]=1, data[a]=xbar_wbuf_data_i. Occupied slot: fill stalls.
//   - Read: rc_wbuf_req_ready_o = valid_Q[a_req] & (~rtn_valid_Q | rc_wbuf_rtn_ready_i).
//     Request to empty slot stalls (ready=0) until the slot is filled; no fill->read bypass:
//     fill fires cycle N, read of same slot may fire earliest N+1.
//   - Req fire cycle N: output register <= data[a], rtn_valid=1 from N+1 (latency 1);
//     valid[a] cleared at N+1 (slot freed at accept, data already captured).
//   - Return: rtn_valid/data held stable while rc_wbuf_rtn_ready_i=0. rtn fire with no new req
//     -> rtn_valid=0 next cycle. rtn fire + req fire same cycle -> rtn_valid stays 1, new data
//     (full throughput, one request per cycle).
//   - Same slot fill + req same cycle: fill stalls (slot still valid); no overwrite; fill fires
//     the following cycle once freed.
//   - Different slots fill + req same cycle: both fire; wbuf_valid_cnt_o unchanged.
//   - Counter: +1 on fill fire, -1 on req fire, unchanged on both; cannot exceed DEPTH or wrap
//     below 0 by construction (both gated by slot valid).
// TESTING
//   1 Reset: rtn_valid=0, cnt=0, fill_ready=1, req_valid=1 to ch0/id0 -> req_ready=0 indefinitely.
//   2 Fill ch1/id2 data=0xA5..A5 cycle N; req ch1/id2 at N+1 -> req_ready=1, rtn_valid=1 at N+2
//     with 0xA5..A5; cnt 0->1->0.
//   3 Hold rtn_ready=0 3 cycles with second req pending on filled slot -> req_ready=0, rtn data
//     stable; raise rtn_ready -> both fire same cycle, next data returned back-to-back.
//   4 Fill all 16 slots -> cnt=16, fill to any slot ready=0; read ch3/id3 -> fill ch3/id3 accepted
//     the cycle after the read fires, cnt returns to 16.
//   5 Same-cycle fill and req to ch0/id0 (slot valid, old=0x1, new=0x2) -> rtn 0x1, fill accepted
//     next cycle, subsequent read returns 0x2.
//   6 Assert rst_i while rtn_valid=1 and 5 slots full -> all outputs at reset values immediately.

Source files
------------

// File: rtl/bank_wbuf_responder.sv
// -----------------------------------------------------------------------------
// bank_wbuf_responder
//
// Bank-side write buffer, responder end of the rc_wbuf req/rtn interface.
// The crossbar fills slots addressed by {channel_id, wbuffer_id}; the bank
// SRAM controller later reads a slot, which returns that slot's data one
// cycle after the request is accepted and frees the slot at the same time.
//
// Ports
//   clk_i                     clock
//   rst_i                     asynchronous active-high reset
//   xbar_wbuf_valid_i         fill request valid
//   xbar_wbuf_ready_o         fill accepted (target slot is free)
//   xbar_wbuf_channel_id_i    fill channel
//   xbar_wbuf_wbuffer_id_i    fill slot id (only low log2(ENTRY_NUM) bits used)
//   xbar_wbuf_data_i          fill data
//   rc_wbuf_req_valid_i       read request valid
//   rc_wbuf_req_ready_o       read request accepted
//   rc_wbuf_req_channel_id_i  read channel
//   rc_wbuf_req_wbuffer_id_i  read slot id (only low log2(ENTRY_NUM) bits used)
//   rc_wbuf_rtn_valid_o       return data valid
//   rc_wbuf_rtn_ready_i       return data consumed
//   rc_wbuf_rtn_data_o        return data
//   wbuf_valid_cnt_o          number of occupied slots
// -----------------------------------------------------------------------------
module bank_wbuf_responder #(
   parameter  int CH_NUM    = 4,
   parameter  int ENTRY_NUM = 4,
   parameter  int DW        = 128,
   localparam int CHW       = $clog2(CH_NUM),
   localparam int DEPTH     = CH_NUM * ENTRY_NUM,
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,

   input  logic          xbar_wbuf_valid_i,
   output logic          xbar_wbuf_ready_o,
   input  logic [CHW-1:0] xbar_wbuf_channel_id_i,
   input  logic [7:0]    xbar_wbuf_wbuffer_id_i,
   input  logic [DW-1:0] xbar_wbuf_data_i,

   input  logic          rc_wbuf_req_valid_i,
   output logic          rc_wbuf_req_ready_o,
   input  logic [CHW-1:0] rc_wbuf_req_channel_id_i,
   input  logic [7:0]    rc_wbuf_req_wbuffer_id_i,

   output logic          rc_wbuf_rtn_valid_o,
   input  logic          rc_wbuf_rtn_ready_i,
   output logic [DW-1:0] rc_wbuf_rtn_data_o,

   output logic [CW-1:0] wbuf_valid_cnt_o
);

   localparam int EW = $clog2(ENTRY_NUM);
   localparam int AW = CHW + EW;

   logic [DEPTH-1:0] valid_q;
   logic [DW-1:0]    mem [DEPTH];
   logic             rtn_valid_q;
   logic [DW-1:0]    rtn_data_q;
   logic [CW-1:0]    cnt_q;

   logic [AW-1:0]    fill_addr;
   logic [AW-1:0]    req_addr;
   logic             fill_fire;
   logic             req_fire;

   // Upper wbuffer_id bits carry no meaning for this buffer size.
   logic             unused_id_bits;
   assign unused_id_bits = ^{xbar_wbuf_wbuffer_id_i[7:EW], rc_wbuf_req_wbuffer_id_i[7:EW]};

   assign fill_addr = {xbar_wbuf_channel_id_i,   xbar_wbuf_wbuffer_id_i[EW-1:0]};
   assign req_addr  = {rc_wbuf_req_channel_id_i, rc_wbuf_req_wbuffer_id_i[EW-1:0]};

   // Both readies look only at registered slot state, so a fill can never be
   // read in the same cycle and a same-slot fill waits until the read frees it.
   assign xbar_wbuf_ready_o   = ~valid_q[fill_addr];
   assign rc_wbuf_req_ready_o = valid_q[req_addr] & (~rtn_valid_q | rc_wbuf_rtn_ready_i);

   assign fill_fire = xbar_wbuf_valid_i   & xbar_wbuf_ready_o;
   assign req_fire  = rc_wbuf_req_valid_i & rc_wbuf_req_ready_o;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // right-hand side reads the pre-edge value regardless of statement order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q     <= '0;
         rtn_valid_q <= 1'b0;
         rtn_data_q  <= '0;
         cnt_q       <= '0;
      end else begin
         // fill and req never target the same slot in one cycle: fill needs
         // the slot empty, req needs it occupied.
         if (fill_fire) valid_q[fill_addr] <= 1'b1;
         if (req_fire)  valid_q[req_addr]  <= 1'b0;

         // The output register reloads on every accepted request; a consumed
         // return with no new request just drops valid and keeps the data.
         if (req_fire) begin
            rtn_valid_q <= 1'b1;
            rtn_data_q  <= mem[req_addr];
         end else if (rc_wbuf_rtn_ready_i) begin
            rtn_valid_q <= 1'b0;
         end

         unique case ({fill_fire, req_fire})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // NOTE: the data array is deliberately left out of reset; the per-slot
   // valid bit alone decides whether its contents are meaningful.
   always_ff @(posedge clk_i) begin
      if (fill_fire) mem[fill_addr] <= xbar_wbuf_data_i;
   end

   assign rc_wbuf_rtn_valid_o = rtn_valid_q;
   assign rc_wbuf_rtn_data_o  = rtn_data_q;
   assign wbuf_valid_cnt_o    = cnt_q;

endmodule

// File: tb/tb_bank_wbuf_responder.sv
// -----------------------------------------------------------------------------
// tb_bank_wbuf_responder
//
// Directed scenarios plus a randomized run for bank_wbuf_responder. The
// reference model keeps slot occupancy/data in arrays and pending returns in
// a queue, advanced once per clock from the handshake rules.
// -----------------------------------------------------------------------------
module tb_bank_wbuf_responder;

   localparam int DW = 128;

   logic          clk = 1'b0;
   logic          rst = 1'b1;

   logic          fill_valid = 1'b0;
   logic          fill_ready;
   logic [1:0]    fill_ch    = '0;
   logic [7:0]    fill_id    = '0;
   logic [DW-1:0] fill_data  = '0;

   logic          req_valid  = 1'b0;
   logic          req_ready;
   logic [1:0]    req_ch     = '0;
   logic [7:0]    req_id     = '0;

   logic          rtn_valid;
   logic          rtn_ready  = 1'b0;
   logic [DW-1:0] rtn_data;
   logic [4:0]    cnt;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model
   bit            occ   [16];
   logic [DW-1:0] mdata [16];
   logic [DW-1:0] rtnq  [$];

   bank_wbuf_responder dut (
      .clk_i                    (clk),
      .rst_i                    (rst),
      .xbar_wbuf_valid_i        (fill_valid),
      .xbar_wbuf_ready_o        (fill_ready),
      .xbar_wbuf_channel_id_i   (fill_ch),
      .xbar_wbuf_wbuffer_id_i   (fill_id),
      .xbar_wbuf_data_i         (fill_data),
      .rc_wbuf_req_valid_i      (req_valid),
      .rc_wbuf_req_ready_o      (req_ready),
      .rc_wbuf_req_channel_id_i (req_ch),
      .rc_wbuf_req_wbuffer_id_i (req_id),
      .rc_wbuf_rtn_valid_o      (rtn_valid),
      .rc_wbuf_rtn_ready_i      (rtn_ready),
      .rc_wbuf_rtn_data_o       (rtn_data),
      .wbuf_valid_cnt_o         (cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rand_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic int model_cnt();
      int n = 0;
      for (int i = 0; i < 16; i++) n += int'(occ[i]);
      return n;
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 16; i++) occ[i] = 1'b0;
      rtnq.delete();
   endfunction

   // Apply the current inputs to the model for one clock, then move to just
   // after the next rising edge where the next stimulus is driven.
   task automatic advance();
      int fa = {fill_ch, fill_id[1:0]};
      int ra = {req_ch, req_id[1:0]};
      bit ff = fill_valid && !occ[fa];
      bit rf = req_valid && occ[ra] && (rtnq.size() == 0 || rtn_ready);
      if (rtnq.size() != 0 && rtn_ready) void'(rtnq.pop_front());
      if (rf) begin
         occ[ra] = 1'b0;
         rtnq.push_back(mdata[ra]);
      end
      if (ff) begin
         occ[fa]   = 1'b1;
         mdata[fa] = fill_data;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      fill_valid = 1'b0;
      req_valid  = 1'b0;
      rtn_ready  = 1'b0;
      rst        = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      apply_reset();
      fill_ch = 2'd0; fill_id = 8'd0;
      req_valid = 1'b1; req_ch = 2'd0; req_id = 8'd0;
      @(negedge clk);
      vectors++;
      if (rtn_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rtn_valid: got %b exp 0", rtn_valid); end
      vectors++;
      if (rtn_data !== '0) begin miscompares++; $display("FAIL reset_rtn_data: got %h exp 0", rtn_data); end
      vectors++;
      if (cnt !== 5'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d exp 0", cnt); end
      vectors++;
      if (fill_ready !== 1'b1) begin miscompares++; $display("FAIL reset_fill_ready: got %b exp 1", fill_ready); end
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_req_empty_slot cyc%0d: got %b exp 0", i, req_ready); end
         advance();
         @(negedge clk);
      end
      req_valid = 1'b0;
      advance();
   endtask

   task automatic test_fill_read();
      logic [DW-1:0] a5 = {16{8'hA5}};
      apply_reset();
      // Upper id bits set on the fill, clear on the read: same slot.
      fill_valid = 1'b1; fill_ch = 2'd1; fill_id = 8'hF6; fill_data = a5;
      @(negedge clk);
      vectors++;
      if (fill_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready_empty: got %b exp 1", fill_ready); end
      advance();
      fill_valid = 1'b0;
      req_valid = 1'b1; req_ch = 2'd1; req_id = 8'h02; rtn_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1) begin miscompares++; $display("FAIL read_ready_after_fill: got %b exp 1", req_ready); end
      vectors++;
      if (cnt !== 5'd1) begin miscompares++; $display("FAIL cnt_after_fill: got %0d exp 1", cnt); end
      advance();
      req_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (rtn_valid !== 1'b1 || rtn_data !== a5) begin miscompares++; $display("FAIL rtn_latency1: got v=%b d=%h exp v=1 d=%h", rtn_valid, rtn_data, a5); end
      vectors++;
      if (cnt !== 5'd0) begin miscompares++; $display("FAIL cnt_after_read: got %0d exp 0", cnt); end
      advance();
      @(negedge clk);
      vectors++;
      if (rtn_valid !== 1'b0) begin miscompares++; $display("FAIL rtn_drop_after_fire: got %b exp 0", rtn_valid); end
      advance();
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] d0 = rand_data();
      logic [DW-1:0] d1 = rand_data();
      apply_reset();
      fill_valid = 1'b1; fill_ch = 2'd2; fill_id = 8'd0; fill_data = d0;
      advance();
      fill_id = 8'd1; fill_data = d1;
      advance();
      fill_valid = 1'b0;
      req_valid = 1'b1; req_ch = 2'd2; req_id = 8'd0; rtn_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_first_req: got %b exp 1", req_ready); end
      advance();
      req_id = 8'd1; rtn_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (req_ready !== 1'b0 || rtn_valid !== 1'b1 || rtn_data !== d0) begin
            miscompares++;
            $display("FAIL bp_hold cyc%0d: got rdy=%b v=%b d=%h exp rdy=0 v=1 d=%h", i, req_ready, rtn_valid, rtn_data, d0);
         end
         advance();
      end
      rtn_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1 || rtn_data !== d0) begin miscompares++; $display("FAIL bp_release: got rdy=%b d=%h exp rdy=1 d=%h", req_ready, rtn_data, d0); end
      advance();
      req_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (rtn_valid !== 1'b1 || rtn_data !== d1) begin miscompares++; $display("FAIL bp_second_rtn: got v=%b d=%h exp v=1 d=%h", rtn_valid, rtn_data, d1); end
      advance();
      @(negedge clk);
      vectors++;
      if (rtn_valid !== 1'b0 || cnt !== 5'd0) begin miscompares++; $display("FAIL bp_idle: got v=%b cnt=%0d exp v=0 cnt=0", rtn_valid, cnt); end
      advance();
   endtask

   task automatic test_full();
      logic [DW-1:0] fdata [16];
      logic [DW-1:0] nd = rand_data();
      apply_reset();
      for (int s = 0; s < 16; s++) begin
         fdata[s]   = rand_data();
         fill_valid = 1'b1;
         fill_ch    = 2'(s >> 2);
         fill_id    = {6'($urandom), 2'(s)};
         fill_data  = fdata[s];
         @(negedge clk);
         vectors++;
         if (fill_ready !== 1'b1) begin miscompares++; $display("FAIL full_fill_slot%0d: got %b exp 1", s, fill_ready); end
         advance();
      end
      for (int i = 0; i < 4; i++) begin
         fill_ch = 2'($urandom); fill_id = 8'($urandom); fill_data = rand_data();
         @(negedge clk);
         vectors++;
         if (fill_ready !== 1'b0 || cnt !== 5'd16) begin miscompares++; $display("FAIL full_stall%0d: got rdy=%b cnt=%0d exp rdy=0 cnt=16", i, fill_ready, cnt); end
         advance();
      end
      fill_ch = 2'd3; fill_id = 8'd3; fill_data = nd;
      req_valid = 1'b1; req_ch = 2'd3; req_id = 8'd3; rtn_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (fill_ready !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL full_read_cycle: got frdy=%b rrdy=%b exp frdy=0 rrdy=1", fill_ready, req_ready); end
      advance();
      req_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (fill_ready !== 1'b1 || cnt !== 5'd15 || rtn_data !== fdata[15]) begin
         miscompares++;
         $display("FAIL full_refill: got frdy=%b cnt=%0d d=%h exp frdy=1 cnt=15 d=%h", fill_ready, cnt, rtn_data, fdata[15]);
      end
      advance();
      fill_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (cnt !== 5'd16 || rtn_valid !== 1'b0) begin miscompares++; $display("FAIL full_restored: got cnt=%0d v=%b exp cnt=16 v=0", cnt, rtn_valid); end
      req_valid = 1'b1;
      advance();
      req_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (rtn_valid !== 1'b1 || rtn_data !== nd) begin miscompares++; $display("FAIL full_new_data: got v=%b d=%h exp v=1 d=%h", rtn_valid, rtn_data, nd); end
      advance();
   endtask

   task automatic test_same_slot();
      logic [DW-1:0] one = 128'h1;
      logic [DW-1:0] two = 128'h2;
      apply_reset();
      fill_valid = 1'b1; fill_ch = 2'd0; fill_id = 8'd0; fill_data = one;
      advance();
      fill_data = two;
      req_valid = 1'b1; req_ch = 2'd0; req_id = 8'd0; rtn_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (fill_ready !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL same_slot_cycle: got frdy=%b rrdy=%b exp frdy=0 rrdy=1", fill_ready, req_ready); end
      advance();
      req_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (rtn_valid !== 1'b1 || rtn_data !== one || fill_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL same_slot_old: got v=%b d=%h frdy=%b exp v=1 d=%h frdy=1", rtn_valid, rtn_data, fill_ready, one);
      end
      advance();
      fill_valid = 1'b0;
      req_valid  = 1'b1;
      @(negedge clk);
      vectors++;
      if (cnt !== 5'd1 || req_ready !== 1'b1) begin miscompares++; $display("FAIL same_slot_refilled: got cnt=%0d rrdy=%b exp cnt=1 rrdy=1", cnt, req_ready); end
      advance();
      req_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (rtn_valid !== 1'b1 || rtn_data !== two) begin miscompares++; $display("FAIL same_slot_new: got v=%b d=%h exp v=1 d=%h", rtn_valid, rtn_data, two); end
      advance();
   endtask

   task automatic test_random();
      int fa;
      int ra;
      bit exp_rrdy;
      apply_reset();
      for (int c = 0; c < 600; c++) begin
         fill_valid = ($urandom_range(0, 9) < 6);
         fill_ch    = 2'($urandom);
         fill_id    = 8'($urandom);
         fill_data  = rand_data();
         req_valid  = ($urandom_range(0, 9) < 6);
         req_ch     = 2'($urandom);
         req_id     = 8'($urandom);
         rtn_ready  = ($urandom_range(0, 9) < 7);
         fa = {fill_ch, fill_id[1:0]};
         ra = {req_ch, req_id[1:0]};
         exp_rrdy = occ[ra] && (rtnq.size() == 0 || rtn_ready);
         @(negedge clk);
         vectors++;
         if (fill_ready !== !occ[fa] || req_ready !== exp_rrdy) begin
            miscompares++;
            $display("FAIL rand_ready cyc%0d: got frdy=%b rrdy=%b exp frdy=%b rrdy=%b", c, fill_ready, req_ready, !occ[fa], exp_rrdy);
         end
         vectors++;
         if (rtn_valid !== (rtnq.size() != 0) || int'(cnt) !== model_cnt()) begin
            miscompares++;
            $display("FAIL rand_state cyc%0d: got v=%b cnt=%0d exp v=%b cnt=%0d", c, rtn_valid, cnt, rtnq.size() != 0, model_cnt());
         end
         if (rtnq.size() != 0) begin
            vectors++;
            if (rtn_data !== rtnq[0]) begin miscompares++; $display("FAIL rand_data cyc%0d: got %h exp %h", c, rtn_data, rtnq[0]); end
         end
         advance();
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int s = 0; s < 6; s++) begin
         fill_valid = 1'b1; fill_ch = 2'(s >> 2); fill_id = 8'(s & 3); fill_data = rand_data();
         advance();
      end
      fill_valid = 1'b0;
      req_valid = 1'b1; req_ch = 2'd0; req_id = 8'd0; rtn_ready = 1'b0;
      advance();
      req_id = 8'd1;
      fill_valid = 1'b1; fill_ch = 2'd0; fill_id = 8'd2;
      @(negedge clk);
      vectors++;
      if (rtn_valid !== 1'b1 || cnt !== 5'd5) begin miscompares++; $display("FAIL mid_precond: got v=%b cnt=%0d exp v=1 cnt=5", rtn_valid, cnt); end
      #1 rst = 1'b1;
      #1;
      model_clear();
      vectors++;
      if (rtn_valid !== 1'b0 || rtn_data !== '0 || cnt !== 5'd0) begin
         miscompares++;
         $display("FAIL mid_reset_regs: got v=%b d=%h cnt=%0d exp v=0 d=0 cnt=0", rtn_valid, rtn_data, cnt);
      end
      vectors++;
      if (fill_ready !== 1'b1 || req_ready !== 1'b0) begin miscompares++; $display("FAIL mid_reset_ready: got frdy=%b rrdy=%b exp frdy=1 rrdy=0", fill_ready, req_ready); end
      fill_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b0 || cnt !== 5'd0) begin miscompares++; $display("FAIL mid_slots_gone: got rrdy=%b cnt=%0d exp rrdy=0 cnt=0", req_ready, cnt); end
      req_valid = 1'b0;
      advance();
   endtask

   initial begin
      test_reset();
      test_fill_read();
      test_back_to_back();
      test_full();
      test_same_slot();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
